riscv_dmem_responder: RTL and testbench
=======================================

Name: riscv_dmem_responder

Overview:
- Data-memory responder at the memory-stage end of the load/store path.
- Accepts one load/store request per transaction from the execute/memory pipeline, which sends the ALU-computed address and the store data.
- Returns load data after a fixed programmable latency and drives a stall to the pipeline while a transaction is in flight.
- Backs sd/ld/sw/lw/sh/lh/sb/lb (and the unsigned load variants) with a doubleword-organised storage array.

Parameters:
- DEPTH, 512, number of 64-bit doubleword entries; must be a power of two.
- LATENCY, 2, cycles from request acceptance to response; must be at least 1.

Ports:
- i_riscv_clk  in  1  clock; all state updates on the rising edge.
- i_riscv_rst_n  in  1  asynchronous active-low reset.
- i_riscv_dm_req_valid  in  1  request present.
- o_riscv_dm_req_ready  out  1  responder can accept a request.
- i_riscv_dm_we  in  1  1 = store, 0 = load.
- i_riscv_dm_addr  in  64  byte address.
- i_riscv_dm_wdata  in  64  store data; the low bytes are used according to size.
- i_riscv_dm_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double.
- i_riscv_dm_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- o_riscv_dm_rsp_valid  out  1  one-cycle response strobe.
- o_riscv_dm_rdata  out  64  load result; 0 for stores and faults.
- o_riscv_dm_misaligned  out  1  fault flag, valid with rsp_valid.
- o_riscv_dm_stall  out  1  transaction in flight.

Behaviour:
- Reset (asynchronous, on i_riscv_rst_n low):
  - State goes to IDLE; latency counter is 0.
  - rsp_valid = 0, rdata = 0, misaligned = 0, stall = 0, req_ready = 1.
  - The storage array is not reset.
- FSM has three states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - stall = 1 in WAIT and RESP.
- Acceptance happens on the edge where valid && ready are both high; call this cycle T.
  - LATENCY = 1: go IDLE -> RESP.
  - LATENCY > 1: go IDLE -> WAIT and load the counter with LATENCY-2.
  - WAIT decrements the counter each cycle and moves to RESP when the counter is 0.
  - RESP lasts exactly one cycle, then returns to IDLE.
  - rsp_valid is high only in RESP, i.e. in the cycle starting at edge T+LATENCY.
  - The next acceptance can occur at edge T+LATENCY+1 at the earliest.
- Addressing:
  - Array index = addr[log2(DEPTH)+2:3]; upper address bits are ignored, so addresses wrap modulo DEPTH*8.
  - Byte offset = addr[2:0].
- Alignment:
  - A request is misaligned when addr is not a multiple of (1 << size).
  - A misaligned request is still accepted and follows the full latency.
  - It performs no write; the response carries misaligned = 1 and rdata = 0.
- Store:
  - The array write happens at edge T.
  - Only bytes offset .. offset+(1<<size)-1 of the entry change; they take wdata[(8<<size)-1:0]. All other bytes are unchanged.
  - The response has rdata = 0 and misaligned = 0.
- Load:
  - At edge T, the entry is read and the selected field is extracted, extended, and latched into the response register.
  - Extension is zero-fill when unsigned = 1, otherwise sign-fill from the field MSB.
  - size = 11 ignores the unsigned flag.
  - The latched value is held until the response cycle; rdata returns to 0 after RESP.
- Held requests: inputs are ignored outside IDLE. A requester holding valid high is accepted on its next IDLE cycle.
- Reset mid-transaction:
  - A pending response is dropped and no rsp_valid is issued.
  - A store already accepted at edge T remains written.

Test Plan:
- Store then load:
  - sd wdata 0x0000000000100000 at addr 0x0; rsp_valid at T+2 with rdata 0.
  - ld addr 0x0 -> rdata 0x0000000000100000 at its T+2.
  - req_ready is low for 2 cycles after each acceptance.
- Sign and zero extension: sd 0x00000000000080FF at addr 0x8, then:
  - lb 0x8 -> 0xFFFFFFFFFFFFFFFF.
  - lbu 0x9 -> 0x0000000000000080.
  - lh 0x8 -> 0xFFFFFFFFFFFF80FF.
  - lhu 0x8 -> 0x00000000000080FF.
- Partial write:
  - sd 0 at addr 0x10, then sw 0xDEADBEEF at addr 0x14.
  - ld 0x10 -> 0xDEADBEEF00000000.
  - lw 0x14 -> 0xFFFFFFFFDEADBEEF.
  - lwu 0x14 -> 0x00000000DEADBEEF.
- Misalignment:
  - lw addr 0x2 -> misaligned = 1, rdata 0.
  - sh addr 0x11 -> misaligned = 1; a following ld 0x10 is unchanged.
- Handshake and wrap:
  - valid held high for two back-to-back loads -> the second is accepted exactly at T+3.
  - sd 0x55 at addr DEPTH*8 aliases to addr 0: ld 0x0 -> 0x55.
- Reset mid-operation:
  - Assert i_riscv_rst_n low in the WAIT cycle of an ld -> no rsp_valid, req_ready = 1 and stall = 0 immediately.
  - After release, an ld of a previously stored address returns the stored value.

Source files
------------

// File: rtl/riscv_dmem_responder_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_dmem_responder_if
// Load/store request/response bundle between the execute/memory pipeline
// (master) and the data-memory responder (slave).
//   i_riscv_dm_req_valid  request present
//   o_riscv_dm_req_ready  responder can accept a request
//   i_riscv_dm_we         1 = store, 0 = load
//   i_riscv_dm_addr       byte address
//   i_riscv_dm_wdata      store data (low bytes used according to size)
//   i_riscv_dm_size       00 byte, 01 half, 10 word, 11 double
//   i_riscv_dm_unsigned   zero-extend loads when 1
//   o_riscv_dm_rsp_valid  one-cycle response strobe
//   o_riscv_dm_rdata      load result, 0 for stores and faults
//   o_riscv_dm_misaligned fault flag, valid with rsp_valid
//   o_riscv_dm_stall      transaction in flight
// -----------------------------------------------------------------------------
interface riscv_dmem_responder_if;
  logic        i_riscv_dm_req_valid;
  logic        o_riscv_dm_req_ready;
  logic        i_riscv_dm_we;
  logic [63:0] i_riscv_dm_addr;
  logic [63:0] i_riscv_dm_wdata;
  logic [1:0]  i_riscv_dm_size;
  logic        i_riscv_dm_unsigned;
  logic        o_riscv_dm_rsp_valid;
  logic [63:0] o_riscv_dm_rdata;
  logic        o_riscv_dm_misaligned;
  logic        o_riscv_dm_stall;

  modport master (
    output i_riscv_dm_req_valid, i_riscv_dm_we, i_riscv_dm_addr,
           i_riscv_dm_wdata, i_riscv_dm_size, i_riscv_dm_unsigned,
    input  o_riscv_dm_req_ready, o_riscv_dm_rsp_valid, o_riscv_dm_rdata,
           o_riscv_dm_misaligned, o_riscv_dm_stall
  );

  modport slave (
    input  i_riscv_dm_req_valid, i_riscv_dm_we, i_riscv_dm_addr,
           i_riscv_dm_wdata, i_riscv_dm_size, i_riscv_dm_unsigned,
    output o_riscv_dm_req_ready, o_riscv_dm_rsp_valid, o_riscv_dm_rdata,
           o_riscv_dm_misaligned, o_riscv_dm_stall
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_dmem_responder
// Data-memory responder for the load/store path. Accepts one request at a
// time, writes stores / reads loads into a doubleword array on acceptance,
// and answers with a one-cycle response LATENCY cycles later while holding
// stall high.
//   i_riscv_clk    clock, rising edge
//   i_riscv_rst_n  asynchronous active-low reset
//   bus            riscv_dmem_responder_if.slave request/response bundle
// -----------------------------------------------------------------------------
module riscv_dmem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic                   i_riscv_clk,
  input  logic                   i_riscv_rst_n,
  riscv_dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_accept;
  logic             w_misaligned;
  logic [IDX_W-1:0] w_idx;
  logic [2:0]       w_off;
  logic [63:0]      r_mem [DEPTH];
  logic [63:0]      w_rd_word;
  logic [63:0]      w_wr_word;
  logic [63:0]      w_bit_mask;
  logic [7:0]       w_byte_mask;
  logic [63:0]      w_load_val;
  logic [63:0]      r_rdata;
  logic             r_misaligned;

  function automatic logic f_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = off[0];
      2'b10:   f_misaligned = |off[1:0];
      default: f_misaligned = |off;
    endcase
  endfunction

  function automatic logic [7:0] f_size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   f_size_bytes = 8'h01;
      2'b01:   f_size_bytes = 8'h03;
      2'b10:   f_size_bytes = 8'h0F;
      default: f_size_bytes = 8'hFF;
    endcase
  endfunction

  // Bring the addressed field down to bit 0, then sign/zero extend it.
  function automatic logic [63:0] f_extend(input logic [63:0] word, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] s;
    s = word >> {off, 3'b000};
    case (size)
      2'b00:   f_extend = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'b01:   f_extend = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'b10:   f_extend = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: f_extend = s;
    endcase
  endfunction

  // Upper address bits are dropped, so the array aliases modulo DEPTH*8.
  assign w_idx        = bus.i_riscv_dm_addr[IDX_W+2:3];
  assign w_off        = bus.i_riscv_dm_addr[2:0];
  assign w_misaligned = f_misaligned(w_off, bus.i_riscv_dm_size);
  assign w_rd_word    = r_mem[w_idx];
  assign w_load_val   = f_extend(w_rd_word, w_off, bus.i_riscv_dm_size, bus.i_riscv_dm_unsigned);

  // Byte-lane merge: only the lanes covered by the access take new data.
  assign w_byte_mask = f_size_bytes(bus.i_riscv_dm_size) << w_off;

  always_comb begin
    w_bit_mask = '0;
    for (int b = 0; b < 8; b++) begin
      w_bit_mask[b*8 +: 8] = {8{w_byte_mask[b]}};
    end
  end

  assign w_wr_word = (w_rd_word & ~w_bit_mask) |
                     ((bus.i_riscv_dm_wdata << {w_off, 3'b000}) & w_bit_mask);

  // Storage array: no reset, so a store accepted before a reset survives it.
  always_ff @(posedge i_riscv_clk) begin
    if (w_accept && bus.i_riscv_dm_we && !w_misaligned) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
    if (!i_riscv_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_riscv_dm_req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response register: captured on acceptance, held to RESP, cleared after.
  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
    if (!i_riscv_rst_n) begin
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_rdata      <= (bus.i_riscv_dm_we || w_misaligned) ? 64'd0 : w_load_val;
      r_misaligned <= w_misaligned;
    end else if (r_state == S_RESP) begin
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
    end
  end

  assign bus.o_riscv_dm_req_ready  = (r_state == S_IDLE);
  assign bus.o_riscv_dm_stall      = (r_state == S_WAIT) || (r_state == S_RESP);
  assign bus.o_riscv_dm_rsp_valid  = (r_state == S_RESP);
  assign bus.o_riscv_dm_rdata      = r_rdata;
  assign bus.o_riscv_dm_misaligned = r_misaligned;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_riscv_dmem_responder
// Directed bench for riscv_dmem_responder (DEPTH 512, LATENCY 2).
// -----------------------------------------------------------------------------
module tb_riscv_dmem_responder;

  localparam int DEPTH   = 512;
  localparam int LATENCY = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  riscv_dmem_responder_if bus ();

  riscv_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_riscv_clk   (clk),
    .i_riscv_rst_n (rst_n),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request in the current cycle (cycle T), then follow it until
  // the responder is back in IDLE. lat is the cycle index (relative to T) of
  // the response strobe, busy the number of cycles with ready low and stall high.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [63:0] rdata, output logic mis,
                        output int lat, output int busy);
    rdata = 64'd0;
    mis   = 1'b0;
    lat   = 0;
    busy  = 0;
    bus.i_riscv_dm_req_valid = 1'b1;
    bus.i_riscv_dm_we        = we;
    bus.i_riscv_dm_addr      = addr;
    bus.i_riscv_dm_wdata     = wdata;
    bus.i_riscv_dm_size      = size;
    bus.i_riscv_dm_unsigned  = uns;
    @(posedge clk); #1;
    bus.i_riscv_dm_req_valid = 1'b0;
    bus.i_riscv_dm_addr      = 64'hFFFF_FFFF_FFFF_FFF8;
    bus.i_riscv_dm_wdata     = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int i = 1; i <= 12; i++) begin
      if (!bus.o_riscv_dm_req_ready && bus.o_riscv_dm_stall) busy++;
      if (bus.o_riscv_dm_rsp_valid) begin
        lat   = i;
        rdata = bus.o_riscv_dm_rdata;
        mis   = bus.o_riscv_dm_misaligned;
      end
      if (bus.o_riscv_dm_req_ready) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_riscv_dm_req_valid = 1'b0;
    bus.i_riscv_dm_we        = 1'b0;
    bus.i_riscv_dm_addr      = '0;
    bus.i_riscv_dm_wdata     = '0;
    bus.i_riscv_dm_size      = '0;
    bus.i_riscv_dm_unsigned  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_riscv_dm_req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got %b exp 1", bus.o_riscv_dm_req_ready);
    end
    n_checks++;
    if (bus.o_riscv_dm_stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall got %b exp 0", bus.o_riscv_dm_stall);
    end
    n_checks++;
    if (bus.o_riscv_dm_rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.o_riscv_dm_rsp_valid);
    end
    n_checks++;
    if (bus.o_riscv_dm_rdata !== 64'd0 || bus.o_riscv_dm_misaligned !== 1'b0) begin
      n_errors++; $display("FAIL reset_rdata got %h/%b exp 0/0", bus.o_riscv_dm_rdata, bus.o_riscv_dm_misaligned);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic mis; int lat; int busy;
    do_txn(1'b1, 64'h0, 64'h0000_0000_0010_0000, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (lat !== 2 || busy !== 2) begin
      n_errors++; $display("FAIL sd_timing lat %0d busy %0d exp 2 2", lat, busy);
    end
    n_checks++;
    if (rd !== 64'd0 || mis !== 1'b0) begin
      n_errors++; $display("FAIL sd_rsp got %h/%b exp 0/0", rd, mis);
    end
    do_txn(1'b0, 64'h0, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (lat !== 2 || busy !== 2) begin
      n_errors++; $display("FAIL ld_timing lat %0d busy %0d exp 2 2", lat, busy);
    end
    n_checks++;
    if (rd !== 64'h0000_0000_0010_0000 || mis !== 1'b0) begin
      n_errors++; $display("FAIL ld_0 got %h/%b exp 0000000000100000/0", rd, mis);
    end
    n_checks++;
    if (bus.o_riscv_dm_rdata !== 64'd0) begin
      n_errors++; $display("FAIL rdata_after_resp got %h exp 0", bus.o_riscv_dm_rdata);
    end
  endtask

  task automatic test_extension();
    logic [63:0] rd; logic mis; int lat; int busy;
    do_txn(1'b1, 64'h8, 64'h0000_0000_0000_80FF, 2'b11, 1'b0, rd, mis, lat, busy);
    do_txn(1'b0, 64'h8, 64'h0, 2'b00, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_errors++; $display("FAIL lb_8 got %h exp ffffffffffffffff", rd);
    end
    do_txn(1'b0, 64'h9, 64'h0, 2'b00, 1'b1, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h0000_0000_0000_0080) begin
      n_errors++; $display("FAIL lbu_9 got %h exp 0000000000000080", rd);
    end
    do_txn(1'b0, 64'h8, 64'h0, 2'b01, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_80FF) begin
      n_errors++; $display("FAIL lh_8 got %h exp ffffffffffff80ff", rd);
    end
    do_txn(1'b0, 64'h8, 64'h0, 2'b01, 1'b1, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h0000_0000_0000_80FF) begin
      n_errors++; $display("FAIL lhu_8 got %h exp 00000000000080ff", rd);
    end
  endtask

  task automatic test_partial_write();
    logic [63:0] rd; logic mis; int lat; int busy;
    do_txn(1'b1, 64'h10, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    // Upper wdata bits must not leak into the entry on a word store.
    do_txn(1'b1, 64'h14, 64'h1234_5678_DEAD_BEEF, 2'b10, 1'b0, rd, mis, lat, busy);
    do_txn(1'b0, 64'h10, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'hDEAD_BEEF_0000_0000) begin
      n_errors++; $display("FAIL ld_10 got %h exp deadbeef00000000", rd);
    end
    do_txn(1'b0, 64'h14, 64'h0, 2'b10, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'hFFFF_FFFF_DEAD_BEEF) begin
      n_errors++; $display("FAIL lw_14 got %h exp ffffffffdeadbeef", rd);
    end
    do_txn(1'b0, 64'h14, 64'h0, 2'b10, 1'b1, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h0000_0000_DEAD_BEEF) begin
      n_errors++; $display("FAIL lwu_14 got %h exp 00000000deadbeef", rd);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic mis; int lat; int busy;
    do_txn(1'b0, 64'h2, 64'h0, 2'b10, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (mis !== 1'b1 || rd !== 64'd0 || lat !== 2) begin
      n_errors++; $display("FAIL lw_2_mis got mis %b rdata %h lat %0d exp 1 0 2", mis, rd, lat);
    end
    do_txn(1'b1, 64'h11, 64'h0000_0000_0000_ABCD, 2'b01, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (mis !== 1'b1 || rd !== 64'd0) begin
      n_errors++; $display("FAIL sh_11_mis got mis %b rdata %h exp 1 0", mis, rd);
    end
    n_checks++;
    if (bus.o_riscv_dm_misaligned !== 1'b0) begin
      n_errors++; $display("FAIL mis_after_resp got %b exp 0", bus.o_riscv_dm_misaligned);
    end
    do_txn(1'b0, 64'h10, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'hDEAD_BEEF_0000_0000 || mis !== 1'b0) begin
      n_errors++; $display("FAIL ld_10_after_mis got %h/%b exp deadbeef00000000/0", rd, mis);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [2];
    int acc2;
    int nrsp;
    int rsp_at [2];
    acc2 = 0; nrsp = 0;
    d[0] = '0; d[1] = '0; rsp_at[0] = 0; rsp_at[1] = 0;
    bus.i_riscv_dm_req_valid = 1'b1;
    bus.i_riscv_dm_we        = 1'b0;
    bus.i_riscv_dm_addr      = 64'h8;
    bus.i_riscv_dm_size      = 2'b11;
    bus.i_riscv_dm_unsigned  = 1'b0;
    @(posedge clk); #1;
    bus.i_riscv_dm_addr = 64'h10;
    for (int i = 1; i <= 9; i++) begin
      if (bus.o_riscv_dm_rsp_valid && nrsp < 2) begin
        d[nrsp] = bus.o_riscv_dm_rdata;
        rsp_at[nrsp] = i;
        nrsp++;
      end
      if (bus.o_riscv_dm_req_ready && acc2 == 0) acc2 = i;
      else if (acc2 != 0) bus.i_riscv_dm_req_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_riscv_dm_req_valid = 1'b0;
    n_checks++;
    if (acc2 !== 3) begin
      n_errors++; $display("FAIL b2b_accept got cycle %0d exp 3", acc2);
    end
    n_checks++;
    if (nrsp !== 2 || rsp_at[0] !== 2 || rsp_at[1] !== 5) begin
      n_errors++; $display("FAIL b2b_rsp_count got %0d at %0d,%0d exp 2 at 2,5", nrsp, rsp_at[0], rsp_at[1]);
    end
    n_checks++;
    if (d[0] !== 64'h0000_0000_0000_80FF || d[1] !== 64'hDEAD_BEEF_0000_0000) begin
      n_errors++; $display("FAIL b2b_data got %h %h exp 00000000000080ff deadbeef00000000", d[0], d[1]);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] rd; logic mis; int lat; int busy;
    do_txn(1'b1, 64'(DEPTH * 8), 64'h55, 2'b11, 1'b0, rd, mis, lat, busy);
    do_txn(1'b0, 64'h0, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h55) begin
      n_errors++; $display("FAIL wrap_ld_0 got %h exp 0000000000000055", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic mis; int lat; int busy;
    int seen;
    seen = 0;
    bus.i_riscv_dm_req_valid = 1'b1;
    bus.i_riscv_dm_we        = 1'b0;
    bus.i_riscv_dm_addr      = 64'h8;
    bus.i_riscv_dm_size      = 2'b11;
    bus.i_riscv_dm_unsigned  = 1'b0;
    @(posedge clk); #1;
    bus.i_riscv_dm_req_valid = 1'b0;
    n_checks++;
    if (bus.o_riscv_dm_stall !== 1'b1 || bus.o_riscv_dm_req_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_wait_state stall %b ready %b exp 1 0", bus.o_riscv_dm_stall, bus.o_riscv_dm_req_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_riscv_dm_req_ready !== 1'b1 || bus.o_riscv_dm_stall !== 1'b0 || bus.o_riscv_dm_rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset ready %b stall %b rsp %b exp 1 0 0",
                           bus.o_riscv_dm_req_ready, bus.o_riscv_dm_stall, bus.o_riscv_dm_rsp_valid);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.o_riscv_dm_rsp_valid !== 1'b0) seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.o_riscv_dm_rsp_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL mid_reset_dropped got %0d strobes exp 0", seen);
    end
    do_txn(1'b0, 64'h8, 64'h0, 2'b11, 1'b0, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h0000_0000_0000_80FF || lat !== 2) begin
      n_errors++; $display("FAIL after_reset_ld_8 got %h lat %0d exp 00000000000080ff 2", rd, lat);
    end
    do_txn(1'b0, 64'h14, 64'h0, 2'b10, 1'b1, rd, mis, lat, busy);
    n_checks++;
    if (rd !== 64'h0000_0000_DEAD_BEEF) begin
      n_errors++; $display("FAIL after_reset_lwu_14 got %h exp 00000000deadbeef", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_store_load();
    test_extension();
    test_partial_write();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop so a wedged DUT can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
